// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi_lite_reg_slave                                            |
// | Purpose  : AXI4-Lite register bank responder with SLVERR decode and a    |
// |            write-event pulse for user logic.                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module axi_lite_reg_slave #(
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = 32'hA11C_0001
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [31:0]              AWADDR,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [31:0]              ARADDR,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic [32*NUM_REGS-1:0]   regs_out,
    output logic                     wr_pulse,
    output logic [7:0]               wr_idx
);

    localparam int         c_IDX_W    = $clog2(NUM_REGS);
    localparam logic [1:0] c_OKAY     = 2'b00;
    localparam logic [1:0] c_SLVERR   = 2'b10;
    localparam logic [1:0] c_W_IDLE   = 2'd0;
    localparam logic [1:0] c_W_COMMIT = 2'd1;
    localparam logic [1:0] c_W_RESP   = 2'd2;
    localparam logic       c_R_IDLE   = 1'b0;
    localparam logic       c_R_DATA   = 1'b1;

    logic [1:0]         r_wstate;
    logic               r_awready;
    logic               r_wready;
    logic               r_aw_held;
    logic               r_w_held;
    logic [c_IDX_W-1:0] r_aw_idx;
    logic               r_aw_ok;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_bvalid;
    logic [1:0]         r_bresp;
    logic               r_wr_pulse;
    logic [7:0]         r_wr_idx;
    logic [31:0]        r_regs [NUM_REGS];

    logic               r_rstate;
    logic               r_arready;
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;

    logic               w_aw_hs;
    logic               w_w_hs;
    logic [c_IDX_W-1:0] w_aw_idx;
    logic               w_aw_ok;
    logic [c_IDX_W-1:0] w_ar_idx;
    logic               w_ar_ok;
    logic               w_unused;

    assign w_aw_hs  = AWVALID && r_awready;
    assign w_w_hs   = WVALID && r_wready;
    assign w_aw_idx = AWADDR[c_IDX_W+1:2];
    assign w_aw_ok  = (AWADDR[31:c_IDX_W+2] == '0);
    assign w_ar_idx = ARADDR[c_IDX_W+1:2];
    assign w_ar_ok  = (ARADDR[31:c_IDX_W+2] == '0);
    // Byte offset within a register has no meaning on this bus.
    assign w_unused = &{1'b0, AWADDR[1:0], ARADDR[1:0]};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate   <= c_W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_idx   <= '0;
            r_aw_ok    <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_OKAY;
            r_wr_pulse <= 1'b0;
            r_wr_idx   <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_wr_pulse <= 1'b0;
            case (r_wstate)
                c_W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_idx  <= w_aw_idx;
                        r_aw_ok   <= w_aw_ok;
                        r_aw_held <= 1'b1;
                        r_awready <= 1'b0;
                    end else if (!r_aw_held) begin
                        r_awready <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= WDATA;
                        r_wstrb  <= WSTRB;
                        r_w_held <= 1'b1;
                        r_wready <= 1'b0;
                    end else if (!r_w_held) begin
                        r_wready <= 1'b1;
                    end
                    if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
                        r_wstate  <= c_W_COMMIT;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                    end
                end
                c_W_COMMIT: begin
                    // Register 0 is the read-only ID word.
                    if (r_aw_ok && (r_aw_idx != '0)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (r_wstrb[b]) begin
                                r_regs[r_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                            end
                        end
                        r_wr_pulse <= 1'b1;
                        r_wr_idx   <= 8'(r_aw_idx);
                        r_bresp    <= c_OKAY;
                    end else begin
                        r_bresp <= c_SLVERR;
                    end
                    r_bvalid  <= 1'b1;
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                    r_wstate  <= c_W_RESP;
                end
                c_W_RESP: begin
                    if (BREADY) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= c_W_IDLE;
                    end
                end
                default: r_wstate <= c_W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rstate  <= c_R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_OKAY;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    if (r_arready && ARVALID) begin
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= c_R_DATA;
                        if (!w_ar_ok) begin
                            r_rdata <= '0;
                            r_rresp <= c_SLVERR;
                        end else if (w_ar_idx == '0) begin
                            r_rdata <= ID_VALUE;
                            r_rresp <= c_OKAY;
                        end else begin
                            r_rdata <= r_regs[w_ar_idx];
                            r_rresp <= c_OKAY;
                        end
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                c_R_DATA: begin
                    if (RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= c_R_IDLE;
                    end
                end
                default: r_rstate <= c_R_IDLE;
            endcase
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
            assign regs_out[32*k +: 32] = r_regs[k];
        end
    endgenerate

    assign AWREADY  = r_awready;
    assign WREADY   = r_wready;
    assign BVALID   = r_bvalid;
    assign BRESP    = r_bresp;
    assign ARREADY  = r_arready;
    assign RVALID   = r_rvalid;
    assign RDATA    = r_rdata;
    assign RRESP    = r_rresp;
    assign wr_pulse = r_wr_pulse;
    assign wr_idx   = r_wr_idx;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axi_lite_reg_slave                                         |
// | Purpose  : Directed self-checking bench for axi_lite_reg_slave.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_axi_lite_reg_slave;

    localparam int NUM_REGS = 16;

    logic                   ACLK;
    logic                   ARESETn;
    logic                   AWVALID;
    logic                   AWREADY;
    logic [31:0]            AWADDR;
    logic                   WVALID;
    logic                   WREADY;
    logic [31:0]            WDATA;
    logic [3:0]             WSTRB;
    logic                   BVALID;
    logic                   BREADY;
    logic [1:0]             BRESP;
    logic                   ARVALID;
    logic                   ARREADY;
    logic [31:0]            ARADDR;
    logic                   RVALID;
    logic                   RREADY;
    logic [31:0]            RDATA;
    logic [1:0]             RRESP;
    logic [32*NUM_REGS-1:0] regs_out;
    logic                   wr_pulse;
    logic [7:0]             wr_idx;

    int n_checks = 0;
    int n_fail   = 0;

    axi_lite_reg_slave #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (32'hA11C_0001)
    ) u_dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .AWADDR   (AWADDR),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .BRESP    (BRESP),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .ARADDR   (ARADDR),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .regs_out (regs_out),
        .wr_pulse (wr_pulse),
        .wr_idx   (wr_idx)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic step();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ARESETn = 1'b0;
        AWVALID = 1'b0; AWADDR = '0;
        WVALID  = 1'b0; WDATA  = '0; WSTRB = '0;
        BREADY  = 1'b0;
        ARVALID = 1'b0; ARADDR = '0;
        RREADY  = 1'b0;
        repeat (3) @(negedge ACLK);

        // Reset state
        check("rst_awready", 64'(AWREADY), 0);
        check("rst_bvalid",  64'(BVALID), 0);
        check("rst_rvalid",  64'(RVALID), 0);
        check("rst_regs",    64'(|regs_out), 0);
        ARESETn = 1'b1;
        #1;
        check("rel_awready_pre", 64'(AWREADY), 0);
        @(negedge ACLK);
        check("rel_ready", 64'({AWREADY, WREADY, ARREADY}), 64'h7);

        // 1: AW and W in the same cycle
        AWVALID = 1'b1; AWADDR = 32'h4;
        WVALID  = 1'b1; WDATA  = 32'hDEADBEEF; WSTRB = 4'hF;
        BREADY  = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        check("t1_ready_low", 64'({AWREADY, WREADY}), 0);
        check("t1_bvalid_c1", 64'(BVALID), 0);
        step();
        check("t1_bvalid",   64'(BVALID), 1);
        check("t1_bresp",    64'(BRESP), 0);
        check("t1_pulse",    64'(wr_pulse), 1);
        check("t1_idx",      64'(wr_idx), 1);
        check("t1_reg1",     64'(regs_out[63:32]), 64'hDEADBEEF);
        step();
        check("t1_bdone",    64'(BVALID), 0);
        check("t1_pulse_off", 64'(wr_pulse), 0);
        check("t1_aw_still0", 64'(AWREADY), 0);
        step();
        check("t1_ready_back", 64'({AWREADY, WREADY}), 64'h3);

        // 2: W first, AW three cycles later, partial strobes
        BREADY = 1'b0;
        WVALID = 1'b1; WDATA = 32'h11223344; WSTRB = 4'b0101;
        step();
        WVALID = 1'b0;
        check("t2_wready_low", 64'(WREADY), 0);
        check("t2_awready_hi", 64'(AWREADY), 1);
        step();
        step();
        check("t2_no_b_yet", 64'(BVALID), 0);
        AWVALID = 1'b1; AWADDR = 32'h4;
        step();
        AWVALID = 1'b0;
        check("t2_awready_low", 64'(AWREADY), 0);
        step();
        check("t2_bvalid", 64'(BVALID), 1);
        check("t2_reg1",   64'(regs_out[63:32]), 64'hDE22BE44);
        step();
        check("t2_bhold",      64'(BVALID), 1);
        check("t2_aw_during_b", 64'(AWREADY), 0);
        BREADY = 1'b1;
        step();
        check("t2_bdone", 64'(BVALID), 0);
        step();

        // 3: read with RREADY withheld
        RREADY = 1'b0;
        ARVALID = 1'b1; ARADDR = 32'h4;
        step();
        ARVALID = 1'b0;
        check("t3_rvalid",  64'(RVALID), 1);
        check("t3_rdata",   64'(RDATA), 64'hDE22BE44);
        check("t3_rresp",   64'(RRESP), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold", 64'({RVALID, ARREADY, RDATA}), {31'd0, 1'b1, 1'b0, 32'hDE22BE44});
        end
        RREADY = 1'b1;
        step();
        check("t3_rdone",   64'({RVALID, ARREADY}), 64'h1);

        // 4: ID register, illegal write, out-of-range read
        ARVALID = 1'b1; ARADDR = 32'h0;
        step();
        ARVALID = 1'b0;
        check("t4_id_data", 64'(RDATA), 64'hA11C0001);
        check("t4_id_resp", 64'(RRESP), 0);
        step();
        AWVALID = 1'b1; AWADDR = 32'h0;
        WVALID  = 1'b1; WDATA  = 32'hFFFFFFFF; WSTRB = 4'hF;
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        step();
        check("t4_w0_bvalid", 64'(BVALID), 1);
        check("t4_w0_bresp",  64'(BRESP), 2);
        check("t4_w0_pulse",  64'(wr_pulse), 0);
        check("t4_w0_reg0",   64'(regs_out[31:0]), 0);
        step();
        step();
        ARVALID = 1'b1; ARADDR = 32'h40;
        step();
        ARVALID = 1'b0;
        check("t4_oor_valid", 64'(RVALID), 1);
        check("t4_oor_data",  64'(RDATA), 0);
        check("t4_oor_resp",  64'(RRESP), 2);
        step();

        // 5: write and read of the same register on the same handshake edge
        RREADY = 1'b0;
        check("t5_ready_pre", 64'({AWREADY, WREADY, ARREADY}), 64'h7);
        AWVALID = 1'b1; AWADDR = 32'h8;
        WVALID  = 1'b1; WDATA  = 32'h55; WSTRB = 4'hF;
        ARVALID = 1'b1; ARADDR = 32'h8;
        step();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("t5_rd_old", 64'({RVALID, RDATA}), {31'd0, 1'b1, 32'h0});
        step();
        check("t5_pulse", 64'({wr_pulse, wr_idx}), 64'h102);
        check("t5_reg2",  64'(regs_out[95:64]), 64'h55);
        check("t5_rd_hold", 64'(RDATA), 0);
        RREADY = 1'b1;
        step();
        check("t5_rdone", 64'({RVALID, ARREADY}), 64'h1);
        ARVALID = 1'b1; ARADDR = 32'h8;
        step();
        ARVALID = 1'b0;
        check("t5_rd_new", 64'(RDATA), 64'h55);
        step();

        // 5b: read handshake on the very edge that commits the write
        AWVALID = 1'b1; AWADDR = 32'hC;
        WVALID  = 1'b1; WDATA  = 32'hA5A5A5A5; WSTRB = 4'hF;
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARVALID = 1'b1; ARADDR = 32'hC;
        step();
        ARVALID = 1'b0;
        check("t5b_rd_old", 64'(RDATA), 0);
        check("t5b_reg3",   64'(regs_out[127:96]), 64'hA5A5A5A5);
        step();
        step();

        // 6: reset while B is pending
        BREADY = 1'b0;
        AWVALID = 1'b1; AWADDR = 32'h10;
        WVALID  = 1'b1; WDATA  = 32'h1234; WSTRB = 4'hF;
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        step();
        check("t6_bpending", 64'(BVALID), 1);
        #2 ARESETn = 1'b0;
        #1;
        check("t6_rst_bvalid", 64'(BVALID), 0);
        check("t6_rst_regs",   64'(|regs_out), 0);
        check("t6_rst_ready",  64'({AWREADY, WREADY, ARREADY}), 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("t6_rel_pre", 64'({AWREADY, WREADY, ARREADY}), 0);
        @(posedge ACLK);
        #1;
        check("t6_rel_ready", 64'({AWREADY, WREADY, ARREADY}), 64'h7);
        check("t6_rel_bvalid", 64'(BVALID), 0);
        @(negedge ACLK);
        RREADY = 1'b1;
        ARVALID = 1'b1; ARADDR = 32'h4;
        step();
        ARVALID = 1'b0;
        check("t6_reg1_cleared", 64'({RVALID, RDATA}), {31'd0, 1'b1, 32'h0});
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
- AXI4-Lite responder exposing a bank of 32-bit registers to an axi_master.
- Accepts AW and W independently and in any order, commits the write with WSTRB byte enables, then returns B.
- Serves AR/R with one-cycle latency.
- Decodes illegal accesses to SLVERR and exports the register bank plus a write-event pulse to user logic.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; power of 2, 2..256.
- ID_VALUE, 32'hA11C_0001, constant returned by register 0, which is read-only.

Ports:
- ACLK  in  1  bus clock, all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- AWADDR  in  32  write byte address
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- WDATA  in  32  write data
- WSTRB  in  4  byte enables, bit i gates WDATA[8i+7:8i]
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- ARADDR  in  32  read byte address
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- RDATA  out  32  read data
- RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
- regs_out  out  32*NUM_REGS  flattened register bank; register k at [32k+31:32k]
- wr_pulse  out  1  one-cycle pulse on every committed OKAY write
- wr_idx  out  8  register index of the write flagged by wr_pulse

Behaviour:
- Reset (ARESETn=0, async): all outputs 0, every register 0 (register 0 reads ID_VALUE), write and read FSMs return to idle.
- AWREADY, WREADY and ARREADY rise on the first ACLK edge after ARESETn deasserts.
- Reset mid-transaction aborts it with no B or R issued.
- Decode: idx = ADDR[log2(NUM_REGS)+1:2]; ADDR[1:0] ignored.
- Out of range: ADDR[31:log2(NUM_REGS)+2] != 0.
- Write path, states W_IDLE, W_COMMIT, W_RESP:
  - W_IDLE: AWREADY holds high until an AW handshake latches the address, then drops. WREADY behaves the same for W, latching WDATA and WSTRB.
  - Both handshakes may occur in the same cycle or in either order; the first one waits for the other.
  - Once both are held, the FSM enters W_COMMIT.
  - W_COMMIT, one cycle: if the address is in range and idx != 0, register bytes with WSTRB=1 are updated, the rest unchanged, wr_pulse=1, wr_idx=idx, BRESP=OKAY.
  - Out-of-range or idx==0 writes change nothing, give no wr_pulse, and return BRESP=SLVERR.
  - BVALID rises on the edge ending W_COMMIT, so BVALID is seen 2 cycles after the later of the AW and W handshakes.
  - W_RESP: BVALID and BRESP hold stable until BREADY.
  - The B handshake returns the FSM to W_IDLE; AWREADY and WREADY reassert on the next edge.
  - AWREADY and WREADY stay 0 from COMMIT through RESP, so at most one write is outstanding.
  - WSTRB=0 in range: OKAY, no byte changes, wr_pulse still asserted.
- Read path, states R_IDLE, R_DATA:
  - R_IDLE: ARREADY=1. The AR handshake captures RDATA and RRESP from register contents as they stand before that edge.
  - On that same edge RVALID=1 and ARREADY=0, giving 1-cycle latency.
  - Out-of-range reads give RDATA=0, RRESP=SLVERR. Index 0 returns ID_VALUE with OKAY.
  - R_DATA: RVALID, RDATA and RRESP are held stable until RREADY. The handshake clears RVALID and sets ARREADY on the same edge.
- Concurrency:
  - Read and write FSMs are fully independent.
  - A write committing on the AR handshake edge is not visible to that read, which returns the old value.
  - Simultaneous AR and AW/W are accepted together.
- VALID/READY compliance: no output VALID depends combinationally on an input READY. All outputs are registered.

Test Plan:
- Reset then AW=0x4 and W=0xDEADBEEF, WSTRB=4'hF, same cycle, BREADY=1 -> BVALID 2 cycles after handshake, BRESP=00, wr_pulse with wr_idx=1, regs_out[63:32]=0xDEADBEEF.
- W first (0x11223344, WSTRB=4'b0101), AW=0x4 three cycles later, on top of 0xDEADBEEF -> reg1=0xDE22BE44, B issued only after AW arrives, AWREADY low during B.
- AR=0x4 with RREADY held 0 for 4 cycles -> RVALID the cycle after AR, RDATA=0xDE22BE44 stable, ARREADY=0 until the RREADY handshake.
- AR=0x0 -> RDATA=0xA11C0001, RRESP=00. Write 0x0 -> BRESP=10, no wr_pulse. AR=0x40 (NUM_REGS=16) -> RDATA=0, RRESP=10.
- Write 0x55 to 0x8 with its AW/W handshake edge coinciding with AR=0x8 -> that read returns 0; a second read returns 0x55.
- ARESETn low while BVALID is pending and BREADY=0 -> BVALID=0 immediately, registers 0. After release, AWREADY=WREADY=ARREADY=1 one edge later.
